// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//   Miss handler between a direct-mapped cache and a fixed-latency main memory.
//   When a miss is taken, a dirty victim line (4 words) is written back first.
//   The 4-word line holding the missed address is then fetched in offset order
//   0..3 and streamed into the cache. A one-cycle fill_done pulse marks the end.
//   Address split: tag[ADDR_W-1 -: TAG_W] | index | offset[OFFSET_W-1:0].
//
// Ports
//   clk_100      system clock, rising edge
//   rst          synchronous active-high reset
//   miss_req     cache miss request, only sampled while idle
//   miss_addr    faulting address, captured with miss_req
//   dirty        victim line dirty flag, captured with miss_req
//   victim_tag   victim line tag, captured with miss_req
//   victim_data  cache word at line_offset (combinational from the cache)
//   line_offset  word offset for victim read and fill write
//   fill_data    word to write into the cache
//   fill_we      cache line write strobe
//   fill_done    one-cycle pulse: the line is installed
//   busy         high from the cycle after capture until fill_done
//   mem_addr     memory word address
//   mem_rd_en    memory read, held MEM_LAT cycles per word
//   mem_wr_en    memory write, held MEM_LAT cycles per word
//   mem_wdata    write-back data
//   mem_rdata    memory read data, valid on the last cycle of each read word
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 8,
    parameter int MEM_LAT  = 3
) (
    input  logic                clk_100,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic                dirty,
    input  logic [TAG_W-1:0]    victim_tag,
    input  logic [DATA_W-1:0]   victim_data,
    output logic [OFFSET_W-1:0] line_offset,
    output logic [DATA_W-1:0]   fill_data,
    output logic                fill_we,
    output logic                fill_done,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int IDX_W = ADDR_W - TAG_W - OFFSET_W;
    // A one-cycle latency still needs a 1-bit counter to keep the vector legal.
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0]    LAST_LAT = LAT_W'(MEM_LAT - 1);
    localparam logic [OFFSET_W-1:0] LAST_OFF = {OFFSET_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TAG_W-1:0]    vtag_q, vtag_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                word_end_s;

    // The word offset of the missed address is irrelevant: whole lines move.
    logic unused_offset_s;
    assign unused_offset_s = ^miss_addr[OFFSET_W-1:0];

    // State and job latches, synchronous reset.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            vtag_q  <= '0;
            off_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            vtag_q  <= vtag_d;
            off_q   <= off_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        vtag_d      = vtag_q;
        off_d       = off_q;
        lat_d       = lat_q;
        line_offset = '0;
        fill_data   = '0;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        busy        = 1'b0;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wdata   = '0;
        word_end_s  = (lat_q == LAST_LAT);

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    tag_d   = miss_addr[ADDR_W-1 -: TAG_W];
                    idx_d   = miss_addr[OFFSET_W +: IDX_W];
                    vtag_d  = victim_tag;
                    off_d   = '0;
                    lat_d   = '0;
                    state_d = dirty ? WB : FILL;
                end else begin
                    state_d = IDLE;
                end
            end

            WB: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = {vtag_q, idx_q, off_q};
                mem_wdata   = victim_data;
                line_offset = off_q;
                if (word_end_s) begin
                    lat_d = '0;
                    // Offset wraps to 0 after the last word, ready for the fill.
                    off_d = off_q + OFFSET_W'(1);
                    if (off_q == LAST_OFF) begin
                        state_d = FILL;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            FILL: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_addr    = {tag_q, idx_q, off_q};
                line_offset = off_q;
                if (word_end_s) begin
                    // Read data is only valid on the final cycle of each word.
                    fill_we   = 1'b1;
                    fill_data = mem_rdata;
                    lat_d     = '0;
                    off_d     = off_q + OFFSET_W'(1);
                    if (off_q == LAST_OFF) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            DONE: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic        clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic        rst;
    logic        miss_req;
    logic [15:0] miss_addr;
    logic        dirty;
    logic [7:0]  victim_tag;
    logic [15:0] mem_rdata;
    logic [15:0] vbase;

    // Outputs of the MEM_LAT=3 instance (index 0) and MEM_LAT=1 instance (index 1)
    logic [1:0]  lo3, lo1;
    logic [15:0] fd3, fd1, ma3, ma1, wd3, wd1, vd3, vd1;
    logic        fwe3, fwe1, fdn3, fdn1, busy3, busy1, rd3, rd1, wr3, wr1;

    // The cache returns vbase+offset for the victim word at line_offset.
    assign vd3 = vbase + {14'd0, lo3};
    assign vd1 = vbase + {14'd0, lo1};

    cache_refill_ctrl #(.MEM_LAT(3)) dut3 (
        .clk_100(clk_100), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .dirty(dirty), .victim_tag(victim_tag), .victim_data(vd3),
        .line_offset(lo3), .fill_data(fd3), .fill_we(fwe3), .fill_done(fdn3),
        .busy(busy3), .mem_addr(ma3), .mem_rd_en(rd3), .mem_wr_en(wr3),
        .mem_wdata(wd3), .mem_rdata(mem_rdata)
    );

    cache_refill_ctrl #(.MEM_LAT(1)) dut1 (
        .clk_100(clk_100), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .dirty(dirty), .victim_tag(victim_tag), .victim_data(vd1),
        .line_offset(lo1), .fill_data(fd1), .fill_we(fwe1), .fill_done(fdn1),
        .busy(busy1), .mem_addr(ma1), .mem_rd_en(rd1), .mem_wr_en(wr1),
        .mem_wdata(wd1), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Job model: a job is (start cycle, dirty, tags, index); outputs follow from
    // elapsed cycles using the latency arithmetic of the refill protocol.
    bit         m_act [2];
    int         m_c   [2];
    bit         m_dirty [2];
    logic [7:0] m_tag [2];
    logic [7:0] m_vtag [2];
    logic [5:0] m_idx [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    always @(posedge clk_100) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
            end else if (!m_act[i]) begin
                if (miss_req) begin
                    m_act[i]   <= 1'b1;
                    m_c[i]     <= cyc;
                    m_dirty[i] <= dirty;
                    m_tag[i]   <= miss_addr[15:8];
                    m_idx[i]   <= miss_addr[7:2];
                    m_vtag[i]  <= victim_tag;
                end
            end else if (cyc - m_c[i] == (m_dirty[i] ? 8 : 4) * lat_of(i) + 1) begin
                m_act[i] <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic model_out(input int i,
                             output logic e_busy, output logic e_rd, output logic e_wr,
                             output logic e_we, output logic e_dn,
                             output logic [15:0] e_addr, output logic [15:0] e_wd,
                             output logic [15:0] e_fd, output logic [1:0] e_lo);
        int L, t, wbn, u, w;
        e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_we = 1'b0; e_dn = 1'b0;
        e_addr = 16'd0; e_wd = 16'd0; e_fd = 16'd0; e_lo = 2'd0;
        if (m_act[i]) begin
            L      = lat_of(i);
            t      = cyc - m_c[i];
            wbn    = m_dirty[i] ? 4 * L : 0;
            e_busy = 1'b1;
            if (t <= wbn) begin
                w      = (t - 1) / L;
                e_wr   = 1'b1;
                e_addr = {m_vtag[i], m_idx[i], w[1:0]};
                e_wd   = vbase + 16'(w);
                e_lo   = w[1:0];
            end else if (t <= wbn + 4 * L) begin
                u      = t - wbn;
                w      = (u - 1) / L;
                e_rd   = 1'b1;
                e_addr = {m_tag[i], m_idx[i], w[1:0]};
                e_lo   = w[1:0];
                if (u % L == 0) begin
                    e_we = 1'b1;
                    e_fd = mem_rdata;
                end
            end else begin
                e_dn = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_dut(input int i, input string p,
                           input logic a_busy, input logic a_rd, input logic a_wr,
                           input logic a_we, input logic a_dn,
                           input logic [15:0] a_addr, input logic [15:0] a_wd,
                           input logic [15:0] a_fd, input logic [1:0] a_lo);
        logic e_busy, e_rd, e_wr, e_we, e_dn;
        logic [15:0] e_addr, e_wd, e_fd;
        logic [1:0] e_lo;
        model_out(i, e_busy, e_rd, e_wr, e_we, e_dn, e_addr, e_wd, e_fd, e_lo);
        chk({p, " busy"}, 32'(a_busy), 32'(e_busy));
        chk({p, " mem_rd_en"}, 32'(a_rd), 32'(e_rd));
        chk({p, " mem_wr_en"}, 32'(a_wr), 32'(e_wr));
        chk({p, " fill_we"}, 32'(a_we), 32'(e_we));
        chk({p, " fill_done"}, 32'(a_dn), 32'(e_dn));
        chk({p, " mem_addr"}, 32'(a_addr), 32'(e_addr));
        chk({p, " mem_wdata"}, 32'(a_wd), 32'(e_wd));
        chk({p, " fill_data"}, 32'(a_fd), 32'(e_fd));
        chk({p, " line_offset"}, 32'(a_lo), 32'(e_lo));
    endtask

    // Per-cycle comparison of both instances against the job model.
    always @(negedge clk_100) begin
        #1;
        if (chk_en) begin
            cmp_dut(0, "L3", busy3, rd3, wr3, fwe3, fdn3, ma3, wd3, fd3, lo3);
            cmp_dut(1, "L1", busy1, rd1, wr1, fwe1, fdn1, ma1, wd1, fd1, lo1);
        end
    end

    // Single miss from reset; literal pins on latency and key addresses.
    task automatic pin_run(input logic [15:0] addr, input logic d, input logic [7:0] vt,
                           input int exp3, input int exp1);
        int d3, d1, n3, n1, we1;
        d3 = 0; d1 = 0; n3 = 0; n1 = 0; we1 = 0;
        @(negedge clk_100);
        rst = 1'b1; miss_req = 1'b0;
        @(negedge clk_100);
        rst = 1'b0; miss_addr = addr; dirty = d; victim_tag = vt;
        vbase = 16'h1110; miss_req = 1'b1;
        @(posedge clk_100);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_100);
            if (k == 1) miss_req = 1'b0;
            mem_rdata = 16'($urandom);
            #1;
            if (fdn3) begin n3++; if (d3 == 0) d3 = k; end
            if (fdn1) begin n1++; if (d1 == 0) d1 = k; end
            if (fwe1 && d == 1'b0) we1++;
            if (k == 1 && d) begin
                chk("pin wb first addr", 32'(ma3), 32'h0A04);
                chk("pin wb first data", 32'(wd3), 32'h1110);
            end
            if (k == 12 && d) begin
                chk("pin wb last addr", 32'(ma3), 32'h0A07);
                chk("pin wb last data", 32'(wd3), 32'h1113);
            end
            if (k == 1 && !d) chk("pin fill first addr", 32'(ma3), 32'hF004);
            if (k == 12 && !d) begin
                chk("pin fill last we", 32'(fwe3), 32'd1);
                chk("pin fill last addr", 32'(ma3), 32'hF007);
                chk("pin fill last off", 32'(lo3), 32'd3);
            end
        end
        chk("pin L3 fill_done cycle", 32'(d3), 32'(exp3));
        chk("pin L1 fill_done cycle", 32'(d1), 32'(exp1));
        chk("pin L3 fill_done count", 32'(n3), 32'd1);
        chk("pin L1 fill_done count", 32'(n1), 32'd1);
        if (!d) chk("pin L1 fill_we count", 32'(we1), 32'd4);
    endtask

    initial begin
        rst = 1'b1; miss_req = 1'b0; miss_addr = 16'd0; dirty = 1'b0;
        victim_tag = 8'd0; mem_rdata = 16'd0; vbase = 16'd0;
        repeat (3) @(negedge clk_100);
        chk_en = 1'b1;
        #1;
        chk("reset busy", 32'(busy3), 32'd0);
        chk("reset mem_addr", 32'(ma3), 32'd0);

        pin_run(16'hF005, 1'b0, 8'h00, 13, 5);
        pin_run(16'hF005, 1'b1, 8'h0A, 25, 9);

        // Reset during write-back word 2, then a clean miss completes.
        @(negedge clk_100);
        miss_addr = 16'hF005; dirty = 1'b1; victim_tag = 8'h0A; miss_req = 1'b1;
        @(posedge clk_100);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_100);
            miss_req = 1'b0;
            rst = (k == 7);
            #1;
            if (k == 8) begin
                chk("rst mid-op busy", 32'(busy3), 32'd0);
                chk("rst mid-op wr_en", 32'(wr3), 32'd0);
                chk("rst mid-op addr", 32'(ma3), 32'd0);
            end
        end
        pin_run(16'hF005, 1'b0, 8'h00, 13, 5);

        // Back-to-back misses with miss_req held high.
        @(negedge clk_100);
        miss_addr = 16'h0010; dirty = 1'b0; miss_req = 1'b1;
        repeat (4) @(negedge clk_100);
        miss_addr = 16'h0020;
        repeat (30) @(negedge clk_100);

        // Randomized traffic including mid-operation resets.
        repeat (4000) begin
            @(negedge clk_100);
            rst = ($urandom_range(0, 399) == 0);
            miss_req = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) miss_addr = 16'($urandom);
            dirty = 1'($urandom_range(0, 1));
            victim_tag = 8'($urandom);
            mem_rdata = 16'($urandom);
            if ($urandom_range(0, 15) == 0) vbase = 16'($urandom);
        end
        @(negedge clk_100);
        rst = 1'b0; miss_req = 1'b0;
        repeat (2) @(negedge clk_100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
